counter_array_x: RTL and testbench
==================================

Name: counter_array_x

Overview:
- Parametrised successor to the fixed three-channel bus counter: NUM_CH independent down/up counters of WIDTH bits with per-channel prescaler, mode, reload and interrupt enable.
- Sits on the MIO bus as a memory-mapped peripheral clocked by the IO clock.
- Output pulses/levels drive the LED/seven-seg test paths; combined irq feeds the CPU INT input.

Parameters:
NUM_CH, 4, number of counter channels (1..2^CH_BITS)
CH_BITS, 2, channel-select address bits
WIDTH, 32, counter/data width (>= 8)
PRE_W, 16, shared prescaler width; prescale exponent range 0..PRE_W-1

Ports:
clk  in  1  sole clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
we  in  1  bus write strobe, one write per asserted cycle
addr  in  CH_BITS+2  {channel, reg}; reg 0=LOAD, 1=CTRL, 2=COUNT, 3=STATUS
wdata  in  WIDTH  write data
rdata  out  WIDTH  combinational read of addressed register
cnt_out  out  NUM_CH  per-channel output (pulse or level, per mode)
irq  out  1  OR over channels of (done & irq_en)

Behaviour:
- Reset (async, immediate): load, count, ctrl, done, cnt_out, prescaler all 0; irq=0; rdata reads 0 for every address.
- CTRL bits: [0] en, [2:1] mode (00 one-shot, 01 periodic, 10 square, 11 free-run up), [3] irq_en, [7:4] pexp; upper bits read 0. A CTRL write never alters count/out.
- Prescaler: shared free-running PRE_W counter pre, +1 every clk, wraps. Channel tick when en=1 and (pexp=0, or pre[pexp-1:0] all ones); pexp >= PRE_W is clamped to PRE_W-1. Ticks are aligned across channels.
- LOAD write: load<=wdata, count<=wdata; out<=1 in mode 10, else 0; done unchanged. Write beats a same-cycle tick (no count change that cycle).
- COUNT write: count<=wdata only.
- STATUS write: wdata[0]=1 clears done. A same-cycle done set wins over clear. STATUS reads {0, out, done}.
- Mode 00 one-shot, per tick: if count!=0, count-1. On the 1->0 step, out<=1 (held) and done<=1. count==0 is idle with no events. LOAD restarts it.
- Mode 01 periodic, per tick: if count>1, count-1. If count==1, count<=load, out=1 for exactly one clk, done<=1. If count==0 and load==0, idle. If count==0 and load!=0, count<=load with no event.
- Mode 10 square: same reload rule as 01, but out toggles at each reload instead of pulsing; done set at each reload.
- Mode 11 free-run up, per tick: count+1. On wrap all-ones->0, one-clk out pulse and done<=1.
- en=0: count, out and done hold; no ticks.
- A mode change takes effect on the next tick. A pulse in progress ends normally.
- Channels >= NUM_CH: reads 0, writes ignored.
- Latency: register update visible on rdata the clk after the write edge. irq follows done/irq_en with one register delay (irq is registered).
- Reset mid-count: everything returns to the reset values asynchronously; no pending pulse survives.

Test Plan:
- Reset check: rst during activity -> cnt_out=0, irq=0, all 16 addresses read 0 after release.
- One-shot: ch0 LOAD=5, CTRL=0x09 (en, mode00, irq_en, pexp0) -> count 5,4,3,2,1,0 on consecutive clks; cnt_out[0] rises with 0 and stays; irq=1 one clk later; STATUS write 1 -> irq=0.
- Periodic with prescale: ch1 LOAD=3, CTRL=0x13 (en, mode01, pexp1) -> tick every 2 clks; cnt_out[1] one-clk pulse every 6 clks; count sequence 3,2,1,3...
- Square: ch2 LOAD=2, CTRL=0x05 -> cnt_out[2] toggles every 2 clks (period 4); done set each reload; irq stays 0 (irq_en=0).
- Free-run wrap: ch3 COUNT=0xFFFFFFFE, CTRL=0x0F -> next ticks 0xFFFFFFFF, 0x00000000 with one-clk pulse and irq.
- Collisions: LOAD write on a tick edge -> count equals wdata, no decrement. STATUS clear on the same clk as a new done -> done stays 1. Write to ch index >= NUM_CH (NUM_CH=3 build) -> ignored, reads 0.

Source files
------------

// File: rtl/counter_array_x.sv
// Memory-mapped array of NUM_CH prescaled down/up counters with one-shot,
// periodic, square and free-run modes; per-channel outputs and a combined irq.
module counter_array_x #(
  parameter int NUM_CH  = 4,
  parameter int CH_BITS = 2,
  parameter int WIDTH   = 32,
  parameter int PRE_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [CH_BITS+1:0]   addr,
  input  logic [WIDTH-1:0]     wdata,
  output logic [WIDTH-1:0]     rdata,
  output logic [NUM_CH-1:0]    cnt_out,
  output logic                 irq
);

  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam logic [1:0] MODE_ONESHOT  = 2'b00;
  localparam logic [1:0] MODE_PERIODIC = 2'b01;
  localparam logic [1:0] MODE_SQUARE   = 2'b10;
  localparam logic [1:0] MODE_FREERUN  = 2'b11;

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Low-bit mask whose all-ones match marks a tick; exponent clamped to PRE_W-1.
  function automatic logic [PRE_W-1:0] pre_mask(input logic [3:0] pexp);
    int e;
    e = (int'(pexp) >= PRE_W) ? (PRE_W - 1) : int'(pexp);
    return {PRE_W{1'b1}} >> (PRE_W - e);
  endfunction

  logic [PRE_W-1:0]   pre_r;
  logic [CH_BITS-1:0] ch_sel_s;
  logic [1:0]         reg_sel_s;
  logic [WIDTH-1:0]   ch_rd_s [NUM_CH];
  logic [NUM_CH-1:0]  irq_src_s;

  assign ch_sel_s  = addr[CH_BITS+1:2];
  assign reg_sel_s = addr[1:0];

  // Shared free-running prescaler keeps ticks aligned across channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_r <= {PRE_W{1'b0}};
    end else begin
      pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] load_r, count_r, load_nxt_s, count_nxt_s, rd_val_s;
    logic [7:0]       ctrl_r, ctrl_nxt_s;
    logic             done_r, out_r, pulse_r;
    logic             done_nxt_s, out_nxt_s, pulse_nxt_s;
    logic             sel_s, tick_s;
    logic [1:0]       mode_s;
    logic [PRE_W-1:0] mask_s;

    assign sel_s  = (ch_sel_s == CH_BITS'(c));
    assign mode_s = ctrl_r[2:1];
    assign mask_s = pre_mask(ctrl_r[7:4]);
    assign tick_s = ctrl_r[0] & ((pre_r & mask_s) == mask_s);

    // Next-state: bus writes first, then the tick; LOAD/COUNT writes suppress the tick.
    always_comb begin
      load_nxt_s  = load_r;
      count_nxt_s = count_r;
      ctrl_nxt_s  = ctrl_r;
      done_nxt_s  = done_r;
      pulse_nxt_s = 1'b0;
      if (pulse_r) begin
        out_nxt_s = 1'b0;
      end else begin
        out_nxt_s = out_r;
      end
      if (we && sel_s && (reg_sel_s == REG_CTRL)) begin
        ctrl_nxt_s = wdata[7:0];
      end else if (we && sel_s && (reg_sel_s == REG_STATUS) && wdata[0]) begin
        done_nxt_s = 1'b0;
      end else begin
        ctrl_nxt_s = ctrl_r;
      end
      if (we && sel_s && (reg_sel_s == REG_LOAD)) begin
        load_nxt_s  = wdata;
        count_nxt_s = wdata;
        out_nxt_s   = (mode_s == MODE_SQUARE);
      end else if (we && sel_s && (reg_sel_s == REG_COUNT)) begin
        count_nxt_s = wdata;
      end else if (tick_s) begin
        case (mode_s)
          MODE_ONESHOT: begin
            if (count_r != ZERO_W) begin
              count_nxt_s = count_r - ONE_W;
              if (count_r == ONE_W) begin
                out_nxt_s  = 1'b1;
                done_nxt_s = 1'b1;
              end else begin
                done_nxt_s = done_nxt_s;
              end
            end else begin
              count_nxt_s = count_r;
            end
          end
          MODE_PERIODIC, MODE_SQUARE: begin
            if (count_r > ONE_W) begin
              count_nxt_s = count_r - ONE_W;
            end else if (count_r == ONE_W) begin
              count_nxt_s = load_r;
              done_nxt_s  = 1'b1;
              if (mode_s == MODE_PERIODIC) begin
                out_nxt_s   = 1'b1;
                pulse_nxt_s = 1'b1;
              end else begin
                out_nxt_s = ~out_r;
              end
            end else if (load_r != ZERO_W) begin
              count_nxt_s = load_r;
            end else begin
              count_nxt_s = count_r;
            end
          end
          MODE_FREERUN: begin
            count_nxt_s = count_r + ONE_W;
            if (&count_r) begin
              out_nxt_s   = 1'b1;
              pulse_nxt_s = 1'b1;
              done_nxt_s  = 1'b1;
            end else begin
              done_nxt_s = done_nxt_s;
            end
          end
          default: begin
            count_nxt_s = count_r;
          end
        endcase
      end else begin
        count_nxt_s = count_r;
      end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        load_r  <= ZERO_W;
        count_r <= ZERO_W;
        ctrl_r  <= 8'h00;
        done_r  <= 1'b0;
        out_r   <= 1'b0;
        pulse_r <= 1'b0;
      end else begin
        load_r  <= load_nxt_s;
        count_r <= count_nxt_s;
        ctrl_r  <= ctrl_nxt_s;
        done_r  <= done_nxt_s;
        out_r   <= out_nxt_s;
        pulse_r <= pulse_nxt_s;
      end
    end

    // Register read mux for this channel.
    always_comb begin
      case (reg_sel_s)
        REG_LOAD:   rd_val_s = load_r;
        REG_CTRL:   rd_val_s = {{(WIDTH-8){1'b0}}, ctrl_r};
        REG_COUNT:  rd_val_s = count_r;
        REG_STATUS: rd_val_s = {{(WIDTH-2){1'b0}}, out_r, done_r};
        default:    rd_val_s = ZERO_W;
      endcase
    end

    assign ch_rd_s[c]   = sel_s ? rd_val_s : ZERO_W;
    assign cnt_out[c]   = out_r;
    assign irq_src_s[c] = done_r & ctrl_r[3];
  end

  // Unpopulated channel indices select nothing and so read as zero.
  always_comb begin
    rdata = ZERO_W;
    for (int c = 0; c < NUM_CH; c++) begin
      rdata = rdata | ch_rd_s[c];
    end
  end

  // Registered interrupt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq <= 1'b0;
    end else begin
      irq <= |irq_src_s;
    end
  end

endmodule

// File: tb/tb_counter_array_x.sv
// Directed bench for counter_array_x: reset, each mode, write/tick collisions
// and unpopulated channels on a NUM_CH=3 build.
module tb_counter_array_x;

  logic        clk, rst, we;
  logic [3:0]  addr;
  logic [31:0] wdata, rdata, rdata3;
  logic [3:0]  cnt_out;
  logic [2:0]  cnt_out3;
  logic        irq, irq3;
  int          n_vec, n_miss;
  logic        found;

  counter_array_x #(.NUM_CH(4), .CH_BITS(2), .WIDTH(32), .PRE_W(16)) dut (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .cnt_out(cnt_out), .irq(irq)
  );

  counter_array_x #(.NUM_CH(3), .CH_BITS(2), .WIDTH(32), .PRE_W(16)) dut3 (
    .clk(clk), .rst(rst), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata3), .cnt_out(cnt_out3), .irq(irq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1;
    we = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    addr = a;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] per_cnt [10];
    logic        per_out [10];
    logic [31:0] sq_cnt  [6];
    logic        sq_out  [6];
    per_cnt = '{32'd2, 32'd1, 32'd1, 32'd3, 32'd3, 32'd2, 32'd2, 32'd1, 32'd1, 32'd3};
    per_out = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    sq_cnt  = '{32'd1, 32'd2, 32'd1, 32'd2, 32'd1, 32'd2};
    sq_out  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    n_vec = 0; n_miss = 0;
    rst = 1'b1; we = 1'b0; addr = 4'd0; wdata = 32'd0;
    #1;
    chk("rst_cnt_out", {28'd0, cnt_out}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    #20;
    @(negedge clk);
    rst = 1'b0;
    step();

    // One-shot on ch0: 5,4,3,2,1,0 then held output and irq a clock later.
    bus_write(4'd0, 32'd5);
    bus_write(4'd1, 32'h09);
    rd(4'd2);
    chk("os_count5", rdata, 32'd5);
    for (int i = 4; i >= 0; i--) begin
      step();
      chk($sformatf("os_count%0d", i), rdata, i);
    end
    chk("os_out_rise", {31'd0, cnt_out[0]}, 32'd1);
    chk("os_irq_lag", {31'd0, irq}, 32'd0);
    step();
    chk("os_irq", {31'd0, irq}, 32'd1);
    chk("os_out_held", {31'd0, cnt_out[0]}, 32'd1);
    chk("os_count_idle", rdata, 32'd0);
    bus_write(4'd3, 32'd1);
    chk("os_status_clr", rdata, 32'd2);
    step();
    chk("os_irq_clr", {31'd0, irq}, 32'd0);

    // LOAD on a tick edge wins; STATUS clear loses to a same-cycle done.
    bus_write(4'd0, 32'd7);
    rd(4'd2);
    chk("col_load_cnt", rdata, 32'd7);
    chk("col_load_out", {31'd0, cnt_out[0]}, 32'd0);
    step();
    chk("col_after_load", rdata, 32'd6);
    bus_write(4'd0, 32'd1);
    chk("col_load1", rdata, 32'd1);
    bus_write(4'd3, 32'd1);
    chk("col_status_race", rdata, 32'd3);
    step();
    chk("col_irq", {31'd0, irq}, 32'd1);
    bus_write(4'd3, 32'd1);
    step();
    chk("col_irq_clr", {31'd0, irq}, 32'd0);

    // Periodic on ch1 with pexp=1: tick every 2 clks, pulse every 6.
    bus_write(4'd4, 32'd3);
    bus_write(4'd5, 32'h13);
    rd(4'd6);
    chk("per_start", rdata, 32'd3);
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      step();
      if (rdata == 32'd2) found = 1'b1;
    end
    chk("per_sync", {31'd0, found}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("per_cnt[%0d]", i), rdata, per_cnt[i]);
      chk($sformatf("per_out[%0d]", i), {31'd0, cnt_out[1]}, {31'd0, per_out[i]});
    end

    // Square on ch2: output toggles every 2 clks, no irq with irq_en=0.
    bus_write(4'd8, 32'd2);
    bus_write(4'd9, 32'h05);
    rd(4'd10);
    chk("sq_start", rdata, 32'd2);
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("sq_cnt[%0d]", i), rdata, sq_cnt[i]);
      chk($sformatf("sq_out[%0d]", i), {31'd0, cnt_out[2]}, {31'd0, sq_out[i]});
    end
    chk("sq_irq", {31'd0, irq}, 32'd0);
    rd(4'd11);
    chk("sq_status", rdata, 32'd3);

    // Free-run on ch3 across the all-ones wrap.
    bus_write(4'd14, 32'hFFFF_FFFE);
    bus_write(4'd13, 32'h0F);
    rd(4'd14);
    chk("fr_start", rdata, 32'hFFFF_FFFE);
    step();
    chk("fr_ones", rdata, 32'hFFFF_FFFF);
    chk("fr_out0", {31'd0, cnt_out[3]}, 32'd0);
    step();
    chk("fr_wrap", rdata, 32'd0);
    chk("fr_pulse", {31'd0, cnt_out[3]}, 32'd1);
    step();
    chk("fr_cnt1", rdata, 32'd1);
    chk("fr_pulse_end", {31'd0, cnt_out[3]}, 32'd0);
    chk("fr_irq", {31'd0, irq}, 32'd1);

    // Asynchronous reset mid-activity clears everything.
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt_out", {28'd0, cnt_out}, 32'd0);
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd(a[3:0]);
      chk($sformatf("rst_rd[%0d]", a), rdata, 32'd0);
    end

    // Channel 3 exists in the 4-channel build only.
    step();
    bus_write(4'd12, 32'h55);
    chk("ch3_full", rdata, 32'h55);
    chk("ch3_absent", rdata3, 32'd0);
    rd(4'd13);
    chk("ch3_absent_ctrl", rdata3, 32'd0);
    bus_write(4'd0, 32'h21);
    chk("ch0_nch3", rdata3, 32'h21);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
